// File: rtl/piso_frame_serializer_pkg.sv
// Shared types and legal parameter ranges for the frame serializer and its counters.
package piso_frame_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

    function automatic bit paramsLegal(input int width, input int gap);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) && (gap >= 0) && (gap <= GAP_MAX);
    endfunction

endpackage

// File: rtl/piso_frame_serializer_if.sv
// Message handshake plus serial line outputs of the frame serializer.
interface piso_frame_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] msgData;
    logic             msgValid;
    logic             msgReady;
    logic             serialOut;
    logic             serialValid;
    logic             frameStart;
    logic             frameEnd;
    logic             busy;

    modport master (
        output msgData, msgValid,
        input  msgReady, serialOut, serialValid, frameStart, frameEnd, busy
    );

    modport slave (
        input  msgData, msgValid,
        output msgReady, serialOut, serialValid, frameStart, frameEnd, busy
    );
endinterface

// File: rtl/piso_frame_serializer_bit_counter.sv
// Saturating up/down counter with synchronous load and a terminal-count flag;
// it holds at the terminal value until reloaded.
module bit_counter #(
    parameter int W        = 4,
    parameter bit COUNT_UP = 1'b1
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic         load_i,
    input  logic         enable_i,
    input  logic [W-1:0] loadValue_i,
    input  logic [W-1:0] terminalValue_i,
    output logic [W-1:0] count_o,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign count_d = COUNT_UP ? (count_q + W'(1)) : (count_q - W'(1));
    assign done_o  = (count_q == terminalValue_i);
    assign count_o = count_q;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadValue_i;
        end else if (enable_i && !done_o) begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/piso_frame_serializer.sv
// Parallel-in/serial-out frame serializer: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock with frame strobes and an optional idle gap.
module piso_frame_serializer
    import piso_frame_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit LSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0,
    parameter int GAP_CYCLES = 0
) (
    input logic                     clock,
    input logic                     resetN,
    piso_frame_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     BIT_TERM   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     BIT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [GAP_CNT_W-1:0] GAP_TERM   = (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    if (!paramsLegal(WIDTH, GAP_CYCLES)) begin : gParamCheck
        $error("piso_frame_serializer: WIDTH or GAP_CYCLES out of range");
    end

    state_t             state_q;
    logic [WIDTH-1:0]   shiftReg_q;
    logic               serialOut_q;
    logic               serialValid_q;
    logic               frameStart_q;
    logic               frameEnd_q;

    logic [WIDTH-1:0]     loadShift_d;
    logic [WIDTH-1:0]     stepShift_d;
    logic                 loadBit_d;
    logic                 stepBit_d;
    logic [CNT_W-1:0]     bitCount;
    logic                 bitDone;
    logic [GAP_CNT_W-1:0] unusedGapCount;
    logic                 gapDone;
    logic                 msgReady;
    logic                 handshake;

    // The first bit leaves on the load edge, so the register keeps only the remaining bits.
    assign loadBit_d   = LSB_FIRST ? bus.msgData[0] : bus.msgData[WIDTH-1];
    assign loadShift_d = LSB_FIRST ? (bus.msgData >> 1) : (bus.msgData << 1);
    assign stepBit_d   = LSB_FIRST ? shiftReg_q[0] : shiftReg_q[WIDTH-1];
    assign stepShift_d = LSB_FIRST ? (shiftReg_q >> 1) : (shiftReg_q << 1);

    assign msgReady  = (state_q == IDLE) ||
                       ((state_q == SHIFT) && bitDone && (GAP_CYCLES == 0));
    assign handshake = bus.msgValid && msgReady;

    bit_counter #(.W(CNT_W)) uBitCounter (
        .clock           (clock),
        .resetN          (resetN),
        .load_i          (handshake),
        .enable_i        ((state_q == SHIFT) && !bitDone),
        .loadValue_i     ('0),
        .terminalValue_i (BIT_TERM),
        .count_o         (bitCount),
        .done_o          (bitDone)
    );

    bit_counter #(.W(GAP_CNT_W)) uGapCounter (
        .clock           (clock),
        .resetN          (resetN),
        .load_i          ((state_q == SHIFT) && bitDone && (GAP_CYCLES > 0)),
        .enable_i        (state_q == GAP),
        .loadValue_i     ('0),
        .terminalValue_i (GAP_TERM),
        .count_o         (unusedGapCount),
        .done_o          (gapDone)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q       <= IDLE;
            shiftReg_q    <= '0;
            serialOut_q   <= IDLE_LEVEL;
            serialValid_q <= 1'b0;
            frameStart_q  <= 1'b0;
            frameEnd_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (handshake) begin
                        state_q       <= SHIFT;
                        shiftReg_q    <= loadShift_d;
                        serialOut_q   <= loadBit_d;
                        serialValid_q <= 1'b1;
                        frameStart_q  <= 1'b1;
                        frameEnd_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!bitDone) begin
                        shiftReg_q    <= stepShift_d;
                        serialOut_q   <= stepBit_d;
                        serialValid_q <= 1'b1;
                        frameStart_q  <= 1'b0;
                        frameEnd_q    <= (bitCount == BIT_PENULT);
                    end else if (GAP_CYCLES > 0) begin
                        state_q       <= GAP;
                        serialOut_q   <= IDLE_LEVEL;
                        serialValid_q <= 1'b0;
                        frameStart_q  <= 1'b0;
                        frameEnd_q    <= 1'b0;
                    end else if (handshake) begin
                        shiftReg_q    <= loadShift_d;
                        serialOut_q   <= loadBit_d;
                        serialValid_q <= 1'b1;
                        frameStart_q  <= 1'b1;
                        frameEnd_q    <= 1'b0;
                    end else begin
                        state_q       <= IDLE;
                        serialOut_q   <= IDLE_LEVEL;
                        serialValid_q <= 1'b0;
                        frameStart_q  <= 1'b0;
                        frameEnd_q    <= 1'b0;
                    end
                end
                GAP: begin
                    if (gapDone) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.msgReady    = msgReady;
    assign bus.busy        = (state_q != IDLE);
    assign bus.serialOut   = serialOut_q;
    assign bus.serialValid = serialValid_q;
    assign bus.frameStart  = frameStart_q;
    assign bus.frameEnd    = frameEnd_q;

endmodule
